// File: rtl/instr_fetch_queue_pkg.sv
// Shared fetch definitions: field widths, fetch-pair bit offsets and the queue entry type.
// No logic, so no latency.
// No flow control at this level; users decide when a pair is accepted.
package instr_fetch_queue_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;
  localparam int ENTRY_W = 64;

  // Bit offsets of each field inside a 128-bit fetch pair.
  localparam int INSTR1_MSB = 127;
  localparam int PC1_MSB    = 95;
  localparam int INSTR0_MSB = 63;
  localparam int PC0_MSB    = 31;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } entry_t;

  // Older half of a fetch pair.
  function automatic entry_t pair_lo(input logic [127:0] pair);
    entry_t e;
    e.instr = pair[INSTR0_MSB -: INSTR_W];
    e.pc    = pair[PC0_MSB -: PC_W];
    return e;
  endfunction

  // Younger half of a fetch pair.
  function automatic entry_t pair_hi(input logic [127:0] pair);
    entry_t e;
    e.instr = pair[INSTR1_MSB -: INSTR_W];
    e.pc    = pair[PC1_MSB -: PC_W];
    return e;
  endfunction

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Bundle between fetch, the instruction queue and dual-issue decode.
// No logic, so no latency.
// stop_fetch throttles fetch; deq_ready throttles the queue toward decode.
interface instr_fetch_queue_if #(
  parameter int DEPTH = 16
);
  import instr_fetch_queue_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic               write_fifo;
  logic [127:0]       fetch_instr_pc;
  logic               flush;
  logic [1:0]         deq_ready;
  logic [INSTR_W-1:0] instr0;
  logic [PC_W-1:0]    pc0;
  logic               valid0;
  logic [INSTR_W-1:0] instr1;
  logic [PC_W-1:0]    pc1;
  logic               valid1;
  logic               stop_fetch;
  logic [CW-1:0]      count;
  logic               overflow_err;

  // Fetch and decode side.
  modport master (
    output write_fifo, fetch_instr_pc, flush, deq_ready,
    input  instr0, pc0, valid0, instr1, pc1, valid1, stop_fetch, count, overflow_err
  );

  // Queue side.
  modport slave (
    input  write_fifo, fetch_instr_pc, flush, deq_ready,
    output instr0, pc0, valid0, instr1, pc1, valid1, stop_fetch, count, overflow_err
  );

endinterface

// File: rtl/instr_fetch_queue_ram.sv
// DEPTH x 64 entry storage: one enable writes two consecutive addresses, two async read ports.
// Write lands on the clock edge; reads are combinational.
// No flow control; the caller guarantees free space before enabling a write.
module fetch_queue_ram
  import instr_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  entry_t        wdat0_i,
  input  entry_t        wdat1_i,
  input  logic [AW-1:0] raddr0_i,
  input  logic [AW-1:0] raddr1_i,
  output entry_t        rdat0_o,
  output entry_t        rdat1_o
);

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] waddr1;

  // Second write address wraps naturally through the AW-bit add.
  assign waddr1 = waddr_i + AW'(1);

  // Data storage is left unreset; validity is tracked by the queue's count.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdat0_i;
      mem_q[waddr1]  <= wdat1_i;
    end
  end

  assign rdat0_o = mem_q[raddr0_i];
  assign rdat1_o = mem_q[raddr1_i];

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction queue: takes fetch pairs, presents the two oldest entries to decode (FWFT).
// A pushed pair is visible the cycle after its write edge; no input-to-output bypass.
// stop_fetch when free <= AFULL_MARGIN; pushes without room are dropped and flagged sticky.
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int AFULL_MARGIN = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  instr_fetch_queue_if.slave q_if
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] TWO_C    = CW'(2);
  localparam logic [CW-1:0] MARGIN_C = CW'(AFULL_MARGIN);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic [CW-1:0] free_w;
  logic          push_req, push, pop0, pop1, valid0, valid1;
  logic [1:0]    pops;
  entry_t        rd0, rd1;

  // Free space uses the registered count, so same-cycle pops never make room for a push.
  assign free_w   = DEPTH_C - count_q;
  assign push_req = q_if.write_fifo & ~q_if.flush;
  assign push     = push_req & (free_w >= TWO_C);

  assign valid0 = (count_q != '0);
  assign valid1 = (count_q >= TWO_C);

  // Strictly in-order retirement: slot1 can only leave together with slot0.
  assign pop0 = valid0 & q_if.deq_ready[0];
  assign pop1 = pop0 & valid1 & q_if.deq_ready[1];
  assign pops = {1'b0, pop0} + {1'b0, pop1};

  fetch_queue_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk      (clk),
    .we_i     (push),
    .waddr_i  (wr_ptr_q),
    .wdat0_i  (pair_lo(q_if.fetch_instr_pc)),
    .wdat1_i  (pair_hi(q_if.fetch_instr_pc)),
    .raddr0_i (rd_ptr_q),
    .raddr1_i (rd_ptr_q + AW'(1)),
    .rdat0_o  (rd0),
    .rdat1_o  (rd1)
  );

  // Next-state for pointers, occupancy and the sticky drop flag; flush wins over push and pop.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (push_req & ~push);
    if (q_if.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(2);
      rd_ptr_d = rd_ptr_q + AW'(pops);
      count_d  = count_q + (push ? TWO_C : '0) - CW'(pops);
    end
  end

  // Queue state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Slots read zero when empty so stale storage never leaks to decode.
  assign q_if.valid0       = valid0;
  assign q_if.valid1       = valid1;
  assign q_if.instr0       = valid0 ? rd0.instr : '0;
  assign q_if.pc0          = valid0 ? rd0.pc    : '0;
  assign q_if.instr1       = valid1 ? rd1.instr : '0;
  assign q_if.pc1          = valid1 ? rd1.pc    : '0;
  assign q_if.stop_fetch   = (free_w <= MARGIN_C);
  assign q_if.count        = count_q;
  assign q_if.overflow_err = overflow_q;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with a reference queue as scoreboard.
// Outputs are sampled on the falling edge, inputs change 1 time unit after the rising edge.
// Covers reset, fill/overflow, in-order pops, deq_ready=10, wrap-around and flush.
module tb_instr_fetch_queue;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  instr_fetch_queue_if #(.DEPTH(16)) q_if ();

  instr_fetch_queue #(.DEPTH(16), .AFULL_MARGIN(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .q_if  (q_if)
  );

  logic [63:0] sb[$];
  logic        ovf_m;
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pair k carries pc0=8k, pc1=8k+4.
  function automatic logic [127:0] mkp(input int k);
    logic [31:0] p0, p1;
    p0 = 32'(8 * k);
    p1 = p0 + 32'd4;
    return {32'hC0DE0000 ^ p1, p1, 32'hC0DE0000 ^ p0, p0};
  endfunction

  task automatic check_model();
    int n;
    n = sb.size();
    chk("count",      64'(q_if.count),        64'(n));
    chk("valid0",     64'(q_if.valid0),       64'(n >= 1));
    chk("valid1",     64'(q_if.valid1),       64'(n >= 2));
    chk("slot0",      {q_if.instr0, q_if.pc0}, (n >= 1) ? sb[0] : 64'd0);
    chk("slot1",      {q_if.instr1, q_if.pc1}, (n >= 2) ? sb[1] : 64'd0);
    chk("stop_fetch", 64'(q_if.stop_fetch),   64'((16 - n) <= 4));
    chk("overflow",   64'(q_if.overflow_err), 64'(ovf_m));
  endtask

  task automatic step(input logic wr, input logic [127:0] d, input logic fl, input logic [1:0] dr);
    int   n;
    logic p0, p1, room;
    q_if.write_fifo     = wr;
    q_if.fetch_instr_pc = d;
    q_if.flush          = fl;
    q_if.deq_ready      = dr;
    @(negedge clk);
    check_model();
    n = sb.size();
    if (fl) begin
      sb.delete();
    end else begin
      p0   = (n >= 1) && dr[0];
      p1   = p0 && (n >= 2) && dr[1];
      room = (16 - n) >= 2;
      if (wr && !room) ovf_m = 1'b1;
      if (p0) void'(sb.pop_front());
      if (p1) void'(sb.pop_front());
      if (wr && room) begin
        sb.push_back(d[63:0]);
        sb.push_back(d[127:64]);
      end
    end
    @(posedge clk);
    #1;
    q_if.write_fifo = 1'b0;
    q_if.flush      = 1'b0;
    q_if.deq_ready  = 2'b00;
  endtask

  task automatic drain();
    for (int g = 0; g < 40 && sb.size() > 0; g++) step(1'b0, 128'd0, 1'b0, 2'b11);
  endtask

  task automatic reset_mid_cycle();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_count",  64'(q_if.count),        64'd0);
    chk("rst_valid0", 64'(q_if.valid0),       64'd0);
    chk("rst_valid1", 64'(q_if.valid1),       64'd0);
    chk("rst_stop",   64'(q_if.stop_fetch),   64'd0);
    chk("rst_ovf",    64'(q_if.overflow_err), 64'd0);
    chk("rst_slot0",  {q_if.instr0, q_if.pc0}, 64'd0);
    sb.delete();
    ovf_m = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n               = 1'b0;
    ovf_m               = 1'b0;
    q_if.write_fifo     = 1'b0;
    q_if.fetch_instr_pc = '0;
    q_if.flush          = 1'b0;
    q_if.deq_ready      = 2'b00;
    #1;
    check_model();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset asserted with six entries held.
    for (int k = 0; k < 3; k++) step(1'b1, mkp(k), 1'b0, 2'b00);
    chk("fill6_count", 64'(q_if.count), 64'd6);
    reset_mid_cycle();

    // Single pair, FWFT presentation on the next cycle.
    step(1'b1, {32'h00000013, 32'h4, 32'h00100093, 32'h0}, 1'b0, 2'b00);
    chk("p1_instr0", 64'(q_if.instr0), 64'h00100093);
    chk("p1_pc0",    64'(q_if.pc0),    64'h0);
    chk("p1_instr1", 64'(q_if.instr1), 64'h00000013);
    chk("p1_pc1",    64'(q_if.pc1),    64'h4);
    chk("p1_count",  64'(q_if.count),  64'd2);
    drain();

    // Fill to full with deq_ready=0, then one dropped push.
    for (int k = 0; k < 6; k++) step(1'b1, mkp(k), 1'b0, 2'b00);
    chk("fill_count12", 64'(q_if.count),      64'd12);
    chk("fill_stop12",  64'(q_if.stop_fetch), 64'd1);
    for (int k = 6; k < 8; k++) step(1'b1, mkp(k), 1'b0, 2'b00);
    chk("fill_count16", 64'(q_if.count), 64'd16);
    step(1'b1, mkp(8), 1'b0, 2'b00);
    chk("drop_count", 64'(q_if.count),        64'd16);
    chk("drop_ovf",   64'(q_if.overflow_err), 64'd1);
    chk("drop_head",  64'(q_if.pc0),          64'd0);
    drain();
    reset_mid_cycle();

    // Push and pop-two together at count=2; then deq_ready=10 at count=3.
    step(1'b1, mkp(100), 1'b0, 2'b00);
    step(1'b1, mkp(101), 1'b0, 2'b11);
    chk("pp_count", 64'(q_if.count), 64'd2);
    chk("pp_head",  64'(q_if.pc0),   64'd808);
    step(1'b1, mkp(102), 1'b0, 2'b00);
    step(1'b0, 128'd0,   1'b0, 2'b01);
    step(1'b0, 128'd0,   1'b0, 2'b10);
    chk("dr10_count", 64'(q_if.count), 64'd3);
    chk("dr10_head",  64'(q_if.pc0),   64'd812);
    drain();

    // Wrap-around: 20 pairs streamed while popping one entry per cycle.
    for (int k = 0; k < 20; k++) begin
      step(1'b1, mkp(k), 1'b0, 2'b01);
      step(1'b0, 128'd0, 1'b0, 2'b01);
    end
    drain();
    chk("wrap_ovf", 64'(q_if.overflow_err), 64'd0);

    // Flush at count=6 with a concurrent write.
    for (int k = 200; k < 203; k++) step(1'b1, mkp(k), 1'b0, 2'b00);
    chk("pre_flush_count", 64'(q_if.count), 64'd6);
    step(1'b1, mkp(203), 1'b1, 2'b11);
    chk("flush_count",  64'(q_if.count),      64'd0);
    chk("flush_valid0", 64'(q_if.valid0),     64'd0);
    chk("flush_stop",   64'(q_if.stop_fetch), 64'd0);
    step(1'b1, mkp(210), 1'b0, 2'b00);
    chk("post_flush_pc0",    64'(q_if.pc0),    64'd1680);
    chk("post_flush_valid0", 64'(q_if.valid0), 64'd1);
    drain();
    check_model();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Instruction buffer directly downstream of the fetch cache controller.
- Each write accepts one 128-bit fetch pair {instr1, pc1, instr0, pc0} and stores it as two in-order 64-bit entries.
- Presents the two oldest instructions to the dual-issue decode stage and back-pressures fetch through stop_fetch.
- Discards all contents when a jump is accepted.

Parameters:
- DEPTH, 16, number of 64-bit {instr,pc} entries; power of two, at least 4.
- AFULL_MARGIN, 4, stop_fetch is asserted while free entries are AFULL_MARGIN or fewer.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- write_fifo  input  1  push the pair on fetch_instr_pc this cycle.
- fetch_instr_pc  input  128  [127:96] instr1, [95:64] pc1, [63:32] instr0, [31:0] pc0.
- flush  input  1  jump accepted; discard contents.
- deq_ready  input  2  decode accepts slot0 (bit0) and slot1 (bit1).
- instr0  output  32  oldest instruction.
- pc0  output  32  PC of instr0.
- valid0  output  1  slot0 holds data.
- instr1  output  32  second-oldest instruction.
- pc1  output  32  PC of instr1.
- valid1  output  1  slot1 holds data.
- stop_fetch  output  1  back-pressure to fetch.
- count  output  $clog2(DEPTH)+1  occupied entries.
- overflow_err  output  1  sticky flag: a push was dropped.

Behaviour:
- Clocking and reset: single clock domain. Asynchronous active-low rst_n clears wr_ptr, rd_ptr, count, overflow_err and the storage valid state. Storage data need not be reset.
- Output reset values: valid0=valid1=0, count=0, stop_fetch=0, overflow_err=0. instr0/pc0/instr1/pc1 read 0.
- Read side is first-word fall-through and combinational from the registers.
  - valid0 = (count>=1); valid1 = (count>=2).
  - Slot0 shows entry rd_ptr; slot1 shows entry rd_ptr+1 mod DEPTH.
  - instr/pc outputs are forced to 0 when their valid is low.
- Pop count:
  - pop0 = valid0 & deq_ready[0].
  - pop1 = pop0 & valid1 & deq_ready[1].
  - deq_ready = 2'b10 pops nothing; the queue retires strictly in order.
  - pops = pop0 + pop1.
- Push rules:
  - push = write_fifo & ~flush & (DEPTH - count >= 2).
  - Free space is evaluated on the registered count, before same-cycle pops.
  - instr0/pc0 is written to wr_ptr; instr1/pc1 is written to wr_ptr+1 mod DEPTH.
  - wr_ptr advances by 2.
  - If write_fifo & ~flush and free < 2, the pair is dropped and overflow_err sets. overflow_err clears only on reset.
- Update: count_next = count + 2*push - pops. rd_ptr advances by pops. Pointers wrap mod DEPTH.
  - Simultaneous push and pops is legal in every state.
- Latency: a pushed pair is visible on the outputs the cycle after the write edge. There is no bypass from fetch_instr_pc to the outputs.
- flush has priority over push and pop. The next cycle has count=0, wr_ptr=rd_ptr=0, valid0=valid1=0. The flush-cycle write is discarded as wrong-path.
- stop_fetch = ((DEPTH - count) <= AFULL_MARGIN), combinational from the registered count.
  - It is 0 in the cycle after a flush.
  - AFULL_MARGIN covers fetch pairs already in flight.

Decomposition:
- Shared fetch package:
  - INSTR_W=32, PC_W=32, ENTRY_W=64.
  - Pair field offsets: INSTR1_MSB=127, PC1_MSB=95, INSTR0_MSB=63, PC0_MSB=31.
  - Entry typedef {instr, pc}.
- One sub-module, fetch_queue_ram: a DEPTH x 64 register array with two write ports (consecutive addresses, single enable) and two asynchronous read ports.
- Pointer, count and flag logic stay in instr_fetch_queue.

Test Plan:
- Reset asserted mid-fill (count=6) -> same cycle: valid0=valid1=0, count=0, stop_fetch=0, overflow_err=0; instr0=pc0=0.
- Push {32'h00000013, 32'h4, 32'h00100093, 32'h0} with deq_ready=0 -> next cycle: valid0=valid1=1, instr0=32'h00100093, pc0=0, instr1=32'h00000013, pc1=4, count=2.
- DEPTH=16, deq_ready=0, 9 pushes:
  - After push 6: count=12, stop_fetch=1.
  - After push 8: count=16.
  - Push 9 is dropped: count stays 16, overflow_err=1.
  - After draining, the data read is still pc 0..60 in order.
- count=2 with write_fifo=1 and deq_ready=2'b11 in the same cycle -> count stays 2; head advances to the new pair.
- count=3 with deq_ready=2'b10 -> no pop, count=3, head unchanged.
- Wrap-around: stream 20 pairs (pc 0,4,...,156) while popping one per cycle -> pops observed in exact pc order across pointer wrap, overflow_err=0.
- Flush at count=6 with write_fifo=1 -> next cycle: count=0, valid0=0, stop_fetch=0; the following push appears at slot0.
